// File: rtl/chacha20_pkg.sv
// chacha20_pkg: shared constants, state encodings and ChaCha20 round arithmetic.
package chacha20_pkg;

    // "expand 32-byte k" as four little-endian words
    localparam logic [31:0] SIGMA0 = 32'h61707865;
    localparam logic [31:0] SIGMA1 = 32'h3320646e;
    localparam logic [31:0] SIGMA2 = 32'h79622d32;
    localparam logic [31:0] SIGMA3 = 32'h6b206574;

    // 20 single rounds = 10 column/diagonal double rounds
    localparam int ROUNDS = 20;

    // UART framing and stream length
    localparam int NUM_BYTES            = 64;
    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        CORE_IDLE,
        CORE_ROUND,
        CORE_FINAL,
        CORE_DONE
    } core_state_e;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    typedef enum logic [1:0] {
        SEQ_WAIT,
        SEQ_SEND,
        SEQ_DRAIN,
        SEQ_DONE
    } seq_state_e;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Returns the updated {a, b, c, d}.
    function automatic logic [127:0] quarter_round(input logic [31:0] a_in,
                                                   input logic [31:0] b_in,
                                                   input logic [31:0] c_in,
                                                   input logic [31:0] d_in);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        a = a_in;
        b = b_in;
        c = c_in;
        d = d_in;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // One round: four independent quarter-rounds over the columns (diag=0)
    // or the diagonals (diag=1). Word i lives at s[32i+31:32i].
    function automatic logic [511:0] chacha_round(input logic [511:0] s, input logic diag);
        logic [511:0] r;
        logic [127:0] q;
        int ia;
        int ib;
        int ic;
        int id;
        r = s;
        for (int j = 0; j < 4; j++) begin
            ia = j;
            ib = 4  + (diag ? ((j + 1) % 4) : j);
            ic = 8  + (diag ? ((j + 2) % 4) : j);
            id = 12 + (diag ? ((j + 3) % 4) : j);
            q  = quarter_round(s[32*ia +: 32], s[32*ib +: 32], s[32*ic +: 32], s[32*id +: 32]);
            r[32*ia +: 32] = q[127:96];
            r[32*ib +: 32] = q[95:64];
            r[32*ic +: 32] = q[63:32];
            r[32*id +: 32] = q[31:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/chacha20_core.sv
// chacha20_core: iterative ChaCha20 block function, one round per cycle.
module chacha20_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter,
    output logic         done,
    output logic [511:0] key_stream
);
    import chacha20_pkg::*;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    core_state_e  state;
    core_state_e  state_next;
    logic [4:0]   round_cnt;
    logic [511:0] init_st;
    logic [511:0] work_st;
    logic [511:0] round_st;
    logic [511:0] final_st;

    // Word 0 at the LSB end: constants, key, counter, nonce.
    assign init_st = {nonce, counter, key, SIGMA3, SIGMA2, SIGMA1, SIGMA0};

    // Even rounds work on columns, odd rounds on diagonals.
    assign round_st = chacha_round(work_st, round_cnt[0]);

    // Feed-forward of the initial state into the permuted state.
    always_comb begin
        final_st = '0;
        for (int i = 0; i < 16; i++) begin
            final_st[32*i +: 32] = work_st[32*i +: 32] + init_st[32*i +: 32];
        end
    end

    // State register and round counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CORE_IDLE;
            round_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == CORE_ROUND) begin
                round_cnt <= round_cnt + 5'd1;
            end else begin
                round_cnt <= '0;
            end
        end
    end

    // Next-state logic: load, 20 rounds, finalize, then hold done.
    always_comb begin
        state_next = state;
        case (state)
            CORE_IDLE:  if (start) state_next = CORE_ROUND;
            CORE_ROUND: if (round_cnt == LAST_ROUND) state_next = CORE_FINAL;
            CORE_FINAL: state_next = CORE_DONE;
            CORE_DONE:  state_next = CORE_DONE;
            default:    state_next = CORE_IDLE;
        endcase
    end

    // Working state and result registers; sequencing comes from the FSM.
    always_ff @(posedge clk) begin
        if (state == CORE_IDLE) begin
            work_st <= init_st;
        end else if (state == CORE_ROUND) begin
            work_st <= round_st;
        end
        if (state == CORE_FINAL) begin
            key_stream <= final_st;
        end
    end

    assign done = (state == CORE_DONE);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter, one byte per valid/ready handshake, back-to-back capable.
module uart_tx
    import chacha20_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);
    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_state_e   state;
    uart_state_e   state_next;
    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] clk_cnt_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    data_q;
    logic          bit_end;
    logic          load;
    logic          tx_next;

    assign bit_end = (clk_cnt == LAST_CNT);

    // State, bit timer, bit index and registered line output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_idx <= bit_idx_next;
            tx      <= tx_next;
        end
    end

    // Capture the byte being framed on each accepted handshake.
    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= data;
        end
    end

    // Frame sequencing; a new byte may be accepted in the last stop-bit cycle.
    always_comb begin
        state_next   = state;
        ready        = 1'b0;
        load         = 1'b0;
        bit_idx_next = bit_idx;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (valid) begin
                    load       = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                bit_idx_next = '0;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == LAST_BIT) state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    ready = 1'b1;
                    if (valid) begin
                        load       = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (state == IDLE || state_next != state || bit_end) begin
            clk_cnt_next = '0;
        end else begin
            clk_cnt_next = clk_cnt + 1'b1;
        end

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = data_q[bit_idx_next];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: rtl/chacha20_uart_top.sv
// chacha20_uart_top: computes one ChaCha20 block after reset and streams it over UART.
module chacha20_uart_top #(
    parameter int           CLK_FREQ     = 50000000,
    parameter int           BAUD         = 115200,
    parameter int           CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter logic [255:0] KEY          = 256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100,
    parameter logic [95:0]  NONCE        = 96'h00000000_4a000000_09000000,
    parameter logic [31:0]  COUNTER      = 32'd1
) (
    input  logic clk,
    input  logic rst,
    output logic uart_tx,
    output logic led_done
);
    import chacha20_pkg::*;

    localparam logic [5:0] LAST_BYTE = 6'(NUM_BYTES - 1);

    logic         core_start;
    logic         core_done;
    logic [511:0] key_stream;
    seq_state_e   seq_state;
    seq_state_e   seq_next;
    logic [5:0]   byte_cnt;
    logic         tx_valid;
    logic         tx_ready;
    logic [7:0]   tx_byte;

    // The core only reacts to start while idle, so holding it high makes it
    // run once on the first cycle out of reset.
    assign core_start = 1'b1;

    chacha20_core u_chacha20 (
        .clk        (clk),
        .rst        (rst),
        .start      (core_start),
        .key        (KEY),
        .nonce      (NONCE),
        .counter    (COUNTER),
        .done       (core_done),
        .key_stream (key_stream)
    );

    // Byte n is key_stream[8n+7:8n]: each word goes out LSB byte first.
    assign tx_byte = key_stream[{byte_cnt, 3'b000} +: 8];

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk   (clk),
        .rst   (rst),
        .valid (tx_valid),
        .data  (tx_byte),
        .ready (tx_ready),
        .tx    (uart_tx)
    );

    // Sequencer state and byte counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_state <= SEQ_WAIT;
            byte_cnt  <= '0;
        end else begin
            seq_state <= seq_next;
            if (tx_valid && tx_ready) begin
                byte_cnt <= byte_cnt + 6'd1;
            end
        end
    end

    // Offer bytes until the last is accepted, then wait for its stop bit.
    always_comb begin
        seq_next = seq_state;
        tx_valid = 1'b0;
        case (seq_state)
            SEQ_WAIT: begin
                tx_valid = core_done;
                if (core_done && tx_ready) seq_next = SEQ_SEND;
            end
            SEQ_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready && byte_cnt == LAST_BYTE) seq_next = SEQ_DRAIN;
            end
            SEQ_DRAIN: begin
                if (tx_ready) seq_next = SEQ_DONE;
            end
            SEQ_DONE: seq_next = SEQ_DONE;
            default:  seq_next = SEQ_WAIT;
        endcase
    end

    assign led_done = (seq_state == SEQ_DONE);

endmodule

// File: tb/tb_chacha20_uart_top.sv
// tb_chacha20_uart_top: scoreboard bench with a cycle-accurate UART frame monitor.
module tb_chacha20_uart_top;

    localparam int CPB   = 8;
    localparam int FRAME = 10 * CPB;

    // RFC 8439 2.3.2 keystream block (key 00..1f, nonce 000000090000004a00000000, counter 1)
    localparam logic [31:0] KS_EXP [16] = '{
        32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
        32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
        32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
        32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2
    };

    logic clk;
    logic rst;
    logic uart_tx;
    logic led_done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] exp_q [$];
    int         frames_rx       = 0;
    int         mon_last_start  = -1;
    int         mon_first_start = -1;

    int         mon_t0;
    logic       mon_aborted;
    logic       mon_shape_ok;
    logic [7:0] mon_rx;
    logic [7:0] mon_exp;
    int         mon_bit;
    logic       mon_eb;

    chacha20_uart_top #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_tx  (uart_tx),
        .led_done (led_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: decode every frame cycle by cycle and compare with the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                mon_t0       = cyc;
                mon_aborted  = 1'b0;
                mon_shape_ok = 1'b1;
                mon_rx       = 8'h00;
                mon_exp      = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
                for (int s = 0; s < FRAME; s++) begin
                    if (s > 0) @(negedge clk);
                    if (rst) begin
                        mon_aborted = 1'b1;
                        break;
                    end
                    mon_bit = s / CPB;
                    case (mon_bit)
                        0:       mon_eb = 1'b0;
                        9:       mon_eb = 1'b1;
                        default: mon_eb = mon_exp[mon_bit-1];
                    endcase
                    if (uart_tx !== mon_eb) mon_shape_ok = 1'b0;
                    if ((s % CPB) == (CPB / 2) && mon_bit >= 1 && mon_bit <= 8) begin
                        mon_rx[mon_bit-1] = uart_tx;
                    end
                end
                if (!mon_aborted) begin
                    if (exp_q.size() == 0) begin
                        check("extra_byte", {56'd0, mon_rx}, 64'hffff_ffff_ffff_ffff);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check($sformatf("byte%0d", frames_rx), {56'd0, mon_rx}, {56'd0, mon_exp});
                        check($sformatf("frame_shape%0d", frames_rx), {63'd0, mon_shape_ok}, 64'd1);
                        if (mon_last_start >= 0) begin
                            check($sformatf("frame_gap%0d", frames_rx), mon_t0 - mon_last_start, FRAME);
                        end else begin
                            mon_first_start = mon_t0;
                        end
                    end
                    mon_last_start = mon_t0;
                    frames_rx++;
                end
            end
        end
    end

    task automatic push_expected();
        logic [31:0] w;
        exp_q.delete();
        for (int n = 0; n < 64; n++) begin
            w = KS_EXP[n / 4];
            exp_q.push_back(w[8*(n % 4) +: 8]);
        end
    endtask

    // Assert reset; outputs must be idle one cycle later.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_rst_tx"}, {63'd0, uart_tx}, 64'd1);
        check({tag, "_rst_led"}, {63'd0, led_done}, 64'd0);
        check({tag, "_rst_core_done"}, {63'd0, dut.u_chacha20.done}, 64'd0);
        repeat (3) @(negedge clk);
    endtask

    // Release reset, then check core latency, keystream and first start bit.
    task automatic release_and_check_core(input string tag);
        int k;
        push_expected();
        frames_rx       = 0;
        mon_last_start  = -1;
        mon_first_start = -1;
        rst = 1'b0;
        k = 0;
        while (k < 30) begin
            @(posedge clk);
            #1;
            k++;
            if (dut.u_chacha20.done === 1'b1) break;
        end
        check({tag, "_core_latency_le24"}, {63'd0, (k <= 24 && dut.u_chacha20.done === 1'b1)}, 64'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_ks_word%0d", tag, i), {32'd0, dut.u_chacha20.key_stream[32*i +: 32]},
                  {32'd0, KS_EXP[i]});
        end
        k = 0;
        while (k < 5) begin
            @(posedge clk);
            #1;
            k++;
            if (uart_tx === 1'b0) break;
        end
        check({tag, "_start_within_2"}, {63'd0, (k >= 1 && k <= 2 && uart_tx === 1'b0)}, 64'd1);
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (frames_rx < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_frames_rx"}, frames_rx, n);
    endtask

    task automatic finish_sequence(input string tag);
        int k;
        wait_frames(tag, 64, 64 * FRAME + 200);
        k = 0;
        while (led_done !== 1'b1 && k < FRAME) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_led_done"}, {63'd0, led_done}, 64'd1);
        check({tag, "_led_time"}, cyc, mon_first_start + 64 * FRAME);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        logic hold_ok;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Full run from reset.
        do_reset("p1");
        release_and_check_core("p1");
        finish_sequence("p1");

        hold_ok = 1'b1;
        repeat (10000) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || led_done !== 1'b1) hold_ok = 1'b0;
        end
        check("p1_hold_idle_done", {63'd0, hold_ok}, 64'd1);
        check("p1_no_retransmit", frames_rx, 64);

        // Reset in the middle of byte 20, then a fresh full run.
        do_reset("p2");
        release_and_check_core("p2");
        wait_frames("p2_pre_abort", 20, 20 * FRAME + 200);
        repeat (5 * CPB) @(negedge clk);
        do_reset("p2_abort");
        check("p2_abort_frames", frames_rx, 20);
        release_and_check_core("p3");
        finish_sequence("p3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/chacha20_uart_top.md
Name: chacha20_uart_top

Overview:
- Self-starting demo top level: after reset, computes one 64-byte ChaCha20 keystream block (RFC 8439) from fixed key/nonce/counter parameters.
- Streams the 64 bytes out over an 8N1 UART TX, then lights a done LED.
- Sits directly on FPGA pins: 50 MHz clock, 115200 baud.

Parameters:
- CLK_FREQ, 50000000, system clock in Hz.
- BAUD, 115200, UART bit rate.
- CLKS_PER_BIT, 434, clock cycles per UART bit (CLK_FREQ/BAUD, truncated).
- KEY, 256'h RFC 8439 §2.3.2 key bytes 00..1f, word i = little-endian bytes 4i..4i+3.
- NONCE, 96'h RFC 8439 §2.3.2 nonce 00 00 00 09 00 00 00 4a 00 00 00 00.
- COUNTER, 32'd1, block counter.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, synchronous, active-high.
- uart_tx  out  1  UART serial output, idle high.
- led_done  out  1  high once all 64 bytes are transmitted.

Behaviour:
- Reset:
  - While rst is high: uart_tx=1, led_done=0, all FSMs idle, core done=0.
  - Reset mid-operation aborts the core and the UART immediately.
  - After rst deasserts, the whole sequence restarts from scratch.
- Core start: first cycle with rst low starts the core. No external start input.
- Core state: 16×32-bit words.
  - Words 0..3: constants 61707865, 3320646e, 79622d32, 6b206574.
  - Words 4..11: KEY.
  - Word 12: COUNTER.
  - Words 13..15: NONCE.
- Core rounds:
  - 10 double rounds. Each double round = column round, then diagonal round.
  - One round (4 parallel quarter-rounds) per cycle, so 20 round cycles.
  - QR: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7.
  - All additions mod 2^32.
- Core finalize:
  - One cycle adds the initial state to the working state word-wise and registers the result into key_stream[511:0]. Word i occupies bits [32i+31:32i].
  - Then done rises and stays high until reset.
  - Latency from reset release to done: at most 24 cycles.
- Core hierarchy: instance name u_chacha20; signals done and key_stream are directly observable.
- Serialization:
  - Byte n (0..63) = key_stream[8n+7:8n], i.e. each word is sent LSB byte first (RFC serialized order).
- UART frame (8N1):
  - Start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit is held exactly CLKS_PER_BIT cycles.
- UART sequencing:
  - Transmission begins within 2 cycles after done.
  - Bytes are sent back-to-back: the next start bit immediately follows the previous stop bit, so each byte takes exactly 10 bit-times.
- UART FSM states: IDLE, START, DATA, STOP. A byte counter 0..63 and a 3-bit data-bit index drive the sequencing.
- Completion:
  - After the stop bit of byte 63 completes, uart_tx stays 1 and led_done=1.
  - Both hold until reset; no retransmission.
- No glitches: uart_tx is a registered output.

Decomposition:
- Package chacha20_pkg: the four sigma constants, round count (20), a quarter-round function, and UART localparams.
- Sub-modules:
  - chacha20_core (instance u_chacha20): ports clk, rst, start, key, nonce, counter, done, key_stream.
  - uart_tx: one byte per valid/ready handshake.
- Top: byte-sequencer FSM plus led_done.

Test Plan:
- Reset, then release -> uart_tx=1 and led_done=0 during reset; u_chacha20.done=1 within 24 cycles of release.
- Keystream check against RFC 8439 §2.3.2 (key 00..1f, nonce 000000090000004a00000000, counter 1):
  - Word 0 of key_stream = e4e7f110; word 15 = 4e3c50a2.
- UART receiver at 434 clk/bit -> 64 bytes received: 10 f1 e7 e4 d1 3b 59 15 … a2 50 3c 4e, zero mismatches versus key_stream.
- Bit timing -> start bit low for exactly 434 cycles; each byte frame spans 4340 cycles; 64 frames total 277760 cycles.
- Completion -> led_done rises after the last stop bit ends and remains 1 with uart_tx=1 for ≥10000 further cycles.
- Assert rst during byte ~20, then release -> output returns high immediately and led_done=0; a full fresh 64-byte sequence repeats from byte 0 (0x10).
